// File: rtl/bus_protocol_pkg.sv
// bus_protocol_pkg: shared types and timing constants for the dValid/dAck bus master
package bus_protocol_pkg;
    localparam int BUS_W = 8;
    typedef logic [2:0] cnt_t;
    localparam cnt_t MIN_VALID = 3'd2;
    localparam cnt_t MAX_VALID = 3'd4;
    typedef enum logic [1:0] {IDLE, VALID, BACKOFF} bus_master_state_t;
endpackage

// File: rtl/bus_protocol_master_if.sv
// bus_protocol_master_if: upstream stream, bus and status signals of the bus master
interface bus_protocol_master_if;
    import bus_protocol_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             dValid;
    logic [BUS_W-1:0] data;
    logic             dAck;
    logic             done;
    logic             err_early_ack;
    logic             err_timeout;
    logic             busy;
    modport master (
        input  in_valid, in_data, dAck,
        output in_ready, dValid, data, done, err_early_ack, err_timeout, busy
    );
    modport slave (
        output in_valid, in_data, dAck,
        input  in_ready, dValid, data, done, err_early_ack, err_timeout, busy
    );
endinterface

// File: rtl/bus_master_fifo.sv
// bus_master_fifo: FIFO_DEPTH x BUS_W synchronous FIFO with full/empty flags
module bus_master_fifo
    import bus_protocol_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [BUS_W-1:0] din_i,
    input  logic             pop_i,
    output logic [BUS_W-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [BUS_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/bus_protocol_master.sv
// bus_protocol_master: FIFO-buffered transmitter for the 8-bit dValid/dAck bus.
// Define BUS_MASTER_RETRY_EN to retransmit a timed-out byte up to MAX_RETRY times.
module bus_protocol_master
    import bus_protocol_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 3
) (
    input logic                   clk,
    input logic                   reset,
    bus_protocol_master_if.master bus
);
    bus_master_state_t state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [BUS_W-1:0]  data_q, data_d, fifo_dout;
    logic              valid_q, valid_d, ack_pend_q, ack_pend_d, dack_q;
    logic              done_q, done_d, early_q, early_d, tout_q, tout_d;
    logic              fifo_full, fifo_empty, pop, ack_rise;
`ifdef BUS_MASTER_RETRY_EN
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`else
    logic unused_max_retry;
    assign unused_max_retry = MAX_RETRY != 0;
`endif
    bus_master_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push_i(bus.in_valid), .din_i(bus.in_data),
        .pop_i(pop), .dout_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty)
    );
    assign ack_rise          = bus.dAck && !dack_q;
    assign bus.in_ready      = !fifo_full;
    assign bus.dValid        = valid_q;
    assign bus.data          = data_q;
    assign bus.done          = done_q;
    assign bus.err_early_ack = early_q;
    assign bus.err_timeout   = tout_q;
    assign bus.busy          = (state_q != IDLE) || !fifo_empty;
    // Next state: launch from the FIFO, count dValid cycles, resolve ack/timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ack_pend_d = ack_pend_q;
        done_d     = 1'b0;
        early_d    = 1'b0;
        tout_d     = 1'b0;
        pop        = 1'b0;
`ifdef BUS_MASTER_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop        = 1'b1;
                data_d     = fifo_dout;
                valid_d    = 1'b1;
                cnt_d      = 3'd1;
                ack_pend_d = 1'b0;
                state_d    = VALID;
`ifdef BUS_MASTER_RETRY_EN
                retry_d    = '0;
`endif
            end
            VALID: begin
                if ((ack_rise && cnt_q >= MIN_VALID) || (ack_pend_q && cnt_q == MIN_VALID)) begin
                    valid_d    = 1'b0;
                    done_d     = 1'b1;
                    ack_pend_d = 1'b0;
                    state_d    = IDLE;
                end else if (ack_rise) begin
                    early_d    = 1'b1;
                    ack_pend_d = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end else if (cnt_q == MAX_VALID) begin
                    valid_d = 1'b0;
`ifdef BUS_MASTER_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = BACKOFF;
                    end else begin
                        tout_d  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    tout_d  = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`ifdef BUS_MASTER_RETRY_EN
            BACKOFF: begin
                valid_d = 1'b1;
                cnt_d   = 3'd1;
                state_d = VALID;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    // State, bus outputs and pulse flags; reset drops dValid at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_pend_q <= 1'b0;
            dack_q     <= 1'b0;
            done_q     <= 1'b0;
            early_q    <= 1'b0;
            tout_q     <= 1'b0;
`ifdef BUS_MASTER_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_pend_q <= ack_pend_d;
            dack_q     <= bus.dAck;
            done_q     <= done_d;
            early_q    <= early_d;
            tout_q     <= tout_d;
`ifdef BUS_MASTER_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_protocol_master.sv
// tb_bus_protocol_master: scoreboard bench with a responding bus target model
module tb_bus_protocol_master;
    import bus_protocol_pkg::*;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_RETRY  = 3;
`ifdef BUS_MASTER_RETRY_EN
    localparam int TRIES = MAX_RETRY + 1;
`else
    localparam int TRIES = 1;
`endif
    typedef struct { int len; logic [7:0] d; bit stable; int gap; } burst_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bus_protocol_master_if bus();
    bus_protocol_master #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    burst_t obs_q[$];
    int ack_at = 0;
    bit hold_ack = 1'b0;
    int n_done = 0, n_early = 0, n_tout = 0, n_rise = 0, full_seen = 0;

    // Target model and burst monitor: raises dAck in dValid cycle ack_at, records each burst
    initial begin
        bit prev_v = 1'b0;
        int vcyc = 0;
        int low_run = -1;
        int gap = -1;
        logic [7:0] bdata = 8'h00;
        bit bstable = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v = 1'b0;
                low_run = -1;
                bus.dAck = hold_ack;
            end else begin
                if (bus.done === 1'b1) n_done++;
                if (bus.err_early_ack === 1'b1) n_early++;
                if (bus.err_timeout === 1'b1) n_tout++;
                if (bus.dValid === 1'b1) begin
                    if (!prev_v) begin
                        vcyc = 1; bdata = bus.data; bstable = 1'b1; gap = low_run; n_rise++;
                    end else begin
                        vcyc++;
                        if (bus.data !== bdata) bstable = 1'b0;
                    end
                    bus.dAck = hold_ack || (ack_at != 0 && vcyc >= ack_at);
                end else begin
                    if (prev_v) begin
                        obs_q.push_back('{vcyc, bdata, bstable, gap});
                        low_run = 0;
                    end
                    if (low_run >= 0) low_run++;
                    bus.dAck = hold_ack;
                end
                prev_v = (bus.dValid === 1'b1);
            end
        end
    end

    task automatic write_byte(input logic [7:0] b, output bit ok);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        if (bus.in_ready !== 1'b1) full_seen++;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = t < 100;
        if (ok) exp_q.push_back(b);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_bursts(input int n, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = obs_q.size() >= n;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dValid !== 1'b0 || bus.data !== 8'h00) begin
            errors++; $display("FAIL reset_bus: dValid=%b data=%h, expected 0/00", bus.dValid, bus.data);
        end
        checks++;
        if ({bus.done, bus.err_early_ack, bus.err_timeout, bus.busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: done/early/tout/busy=%b%b%b%b, expected 0000",
                bus.done, bus.err_early_ack, bus.err_timeout, bus.busy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: in_ready=%b, expected 1", bus.in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack2();
        bit ok;
        burst_t b;
        logic [7:0] e;
        int d0 = n_done;
        ack_at = 2; obs_q.delete(); exp_q.delete();
        write_byte(8'hA5, ok);
        checks++;
        if (bus.dValid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL ack2_pre_launch: dValid=%b busy=%b, expected 0/1", bus.dValid, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.dValid !== 1'b1 || bus.data !== 8'hA5) begin
            errors++; $display("FAIL ack2_launch: dValid=%b data=%h, expected 1/a5", bus.dValid, bus.data);
        end
        wait_bursts(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ack2_burst: got 0 bursts, expected 1");
        end else begin
            b = obs_q.pop_front(); e = exp_q.pop_front();
            if (b.len != 2 || b.d !== e || !b.stable) begin
                errors++; $display("FAIL ack2_burst: len=%0d data=%h stable=%0d, expected 2/%h/1", b.len, b.d, b.stable, e);
            end
        end
        checks++;
        if (n_done - d0 != 1) begin
            errors++; $display("FAIL ack2_done: %0d pulses, expected 1", n_done - d0);
        end
    endtask

    task automatic test_ack4();
        bit ok;
        burst_t b;
        logic [7:0] e;
        int d0 = n_done, t0 = n_tout;
        ack_at = 4; obs_q.delete(); exp_q.delete();
        write_byte(8'h3C, ok);
        wait_bursts(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ack4_burst: got 0 bursts, expected 1");
        end else begin
            b = obs_q.pop_front(); e = exp_q.pop_front();
            if (b.len != 4 || b.d !== e || !b.stable) begin
                errors++; $display("FAIL ack4_burst: len=%0d data=%h stable=%0d, expected 4/%h/1", b.len, b.d, b.stable, e);
            end
        end
        checks++;
        if (n_done - d0 != 1 || n_tout != t0) begin
            errors++; $display("FAIL ack4_pulses: done=%0d tout=%0d, expected 1/0", n_done - d0, n_tout - t0);
        end
    endtask

    task automatic test_early();
        bit ok;
        burst_t b;
        logic [7:0] e;
        int d0 = n_done, e0 = n_early;
        ack_at = 1; obs_q.delete(); exp_q.delete();
        write_byte(8'h5A, ok);
        wait_bursts(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL early_burst: got 0 bursts, expected 1");
        end else begin
            b = obs_q.pop_front(); e = exp_q.pop_front();
            if (b.len != 2 || b.d !== e || !b.stable) begin
                errors++; $display("FAIL early_burst: len=%0d data=%h stable=%0d, expected 2/%h/1", b.len, b.d, b.stable, e);
            end
        end
        checks++;
        if (n_early - e0 != 1 || n_done - d0 != 1) begin
            errors++; $display("FAIL early_pulses: early=%0d done=%0d, expected 1/1", n_early - e0, n_done - d0);
        end
    endtask

    task automatic test_timeout(input bit held);
        bit ok;
        int d0 = n_done, t0 = n_tout;
        ack_at = 0; hold_ack = held; obs_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        write_byte(8'h11, ok);
        wait_bursts(TRIES, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL timeout_bursts(held=%0d): got %0d bursts, expected %0d", held, obs_q.size(), TRIES);
        end
        for (int i = 0; i < TRIES && obs_q.size() > 0; i++) begin
            burst_t b = obs_q.pop_front();
            checks++;
            if (b.len != 4 || b.d !== exp_q[0] || !b.stable || (i > 0 && b.gap != 1)) begin
                errors++; $display("FAIL timeout_try%0d(held=%0d): len=%0d data=%h stable=%0d gap=%0d, expected 4/%h/1/1",
                    i, held, b.len, b.d, b.stable, b.gap, exp_q[0]);
            end
        end
        exp_q.delete();
        checks++;
        if (n_tout - t0 != 1 || n_done != d0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL timeout_end(held=%0d): tout=%0d done=%0d busy=%b, expected 1/0/0",
                held, n_tout - t0, n_done - d0, bus.busy);
        end
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] v;
        int n;
        ack_at = 2; obs_q.delete(); exp_q.delete(); full_seen = 0;
        for (int i = 1; i <= 7; i++) begin
            v = 8'(i);
            write_byte(v, ok);
            if (i == 6) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_full: in_ready=%b after six writes, expected 0", bus.in_ready);
                end
            end
        end
        checks++;
        if (full_seen == 0) begin
            errors++; $display("FAIL b2b_stall: seventh write never stalled, expected in_ready low");
        end
        n = exp_q.size();
        wait_bursts(n, ok);
        checks++;
        if (!ok || obs_q.size() != n) begin
            errors++; $display("FAIL b2b_count: got %0d bursts, expected %0d", obs_q.size(), n);
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            burst_t b = obs_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            checks++;
            if (b.len != 2 || b.d !== e || !b.stable || (i > 0 && b.gap != 1)) begin
                errors++; $display("FAIL b2b_byte%0d: len=%0d data=%h stable=%0d gap=%0d, expected 2/%h/1/1",
                    i, b.len, b.d, b.stable, b.gap, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0;
        ack_at = 0; obs_q.delete(); exp_q.delete();
        write_byte(8'h77, ok);
        write_byte(8'h88, ok);
        write_byte(8'h99, ok);
        checks++;
        if (bus.dValid !== 1'b1 || bus.data !== 8'h77) begin
            errors++; $display("FAIL mid_pre: dValid=%b data=%h, expected 1/77", bus.dValid, bus.data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.dValid !== 1'b0 || bus.data !== 8'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: dValid=%b data=%h busy=%b, expected 0/00/0", bus.dValid, bus.data, bus.busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete(); obs_q.delete();
        r0 = n_rise;
        repeat (20) @(negedge clk);
        checks++;
        if (n_rise != r0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_after: %0d dValid rises busy=%b, expected 0/0", n_rise - r0, bus.busy);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_ack2();
        test_ack4();
        test_early();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_protocol_master.md
# bus_protocol_master

Transmitting master for the 8-bit dValid/dAck bus: accepts bytes from an upstream valid/ready stream into a small FIFO and drives each one onto the bus. It sits directly upstream of the bus target and is the block whose outputs must satisfy the bus protocol checks. Those checks are:
- dValid held 2–4 clocks per transfer.
- data stable from the rise of dValid until the rise of dAck.
- dValid dropped the clock after dAck rises.

## Interface
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, ≥2.
- `MAX_RETRY`, default 3: retransmissions after a timeout before the byte is dropped.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `in_valid`, in, 1: upstream byte valid.
- `in_ready`, out, 1: FIFO not full; combinational.
- `in_data`, in, 8: upstream byte.
- `dValid`, out, 1: bus data valid; registered.
- `data`, out, 8: bus data; registered.
- `dAck`, in, 1: target acknowledge.
- `done`, out, 1: one-cycle pulse when a byte is acknowledged.
- `err_early_ack`, out, 1: one-cycle pulse when dAck rises in the first dValid cycle.
- `err_timeout`, out, 1: one-cycle pulse when a byte is finally dropped.
- `busy`, out, 1: FSM not in IDLE, or FIFO not empty.

## Operation
- **FIFO write:** on `in_valid && in_ready`. `in_ready = !full`; there is no write-through when full, even if a pop happens in the same cycle.
- **Ack detection:** `dAck` is registered into `dAck_q` every cycle. `ack_rise = dAck && !dAck_q`, evaluated only in VALID.
- **IDLE:** if the FIFO is non-empty at the edge:
  - pop the FIFO;
  - load `data`;
  - set `dValid=1`, `cnt=1`, `retry=0`;
  - go to VALID.
- **VALID:** `cnt` counts dValid-high cycles, 1..4. At each edge:
  - `ack_rise` and `cnt≥2`: `dValid<=0`, pulse `done`, go to IDLE.
  - `ack_rise` and `cnt==1`: pulse `err_early_ack`, set `ack_pend`. The byte is treated as acknowledged: dValid drops at the end of `cnt==2`, then `done` is pulsed.
  - No ack and `cnt==4`: timeout. `dValid<=0`.
    - If `retry<MAX_RETRY`: `retry++`, go to BACKOFF.
    - Otherwise pulse `err_timeout` and go to IDLE.
  - Otherwise: `cnt++`.
- **BACKOFF:** exactly one cycle with dValid low. Then `dValid<=1`, `cnt=1`, return to VALID with the same `data`.
- **data stability:** `data` changes only on the IDLE→VALID transition; it is held through VALID, BACKOFF and IDLE.
- **Reset values** (asserted asynchronously): `dValid=0`, `data=0`, `done=0`, `err_*=0`, FIFO empty, FSM IDLE, `cnt=0`, `retry=0`, `ack_pend=0`, `dAck_q=0`.
- **Reset mid-transfer:** dValid drops immediately; the in-flight byte and FIFO contents are discarded.

## Timing
- Byte written at edge N into an empty FIFO with FSM IDLE: dValid rises at edge N+1. data is valid in the same cycle dValid rises.
- dValid high for k cycles, where k = 2..4 on ack, or exactly 4 on timeout.
- dAck rising in cycle k (sampled at the end of k): dValid low from edge k+1.
- At least one dValid-low cycle between transfers; IDLE needs an edge to launch. Back-to-back bytes therefore run at one byte per k+1 cycles.
- `done`, `err_early_ack` and `err_timeout` are registered pulses, asserted in the cycle after the deciding edge.
- dAck held high across transfers does not re-acknowledge: a fresh rise is required.

## Configuration
- `BUS_MASTER_RETRY_EN` defined: timeout → BACKOFF/retry up to `MAX_RETRY`, as above.
- Not defined: the `retry` counter and BACKOFF are removed. Every timeout immediately pulses `err_timeout`, drops the byte and returns to IDLE; `MAX_RETRY` is ignored.

## Structure
- Shared package `bus_protocol_pkg`, holding:
  - `typedef enum {IDLE, VALID, BACKOFF} bus_master_state_t`;
  - `localparam MIN_VALID=2`, `MAX_VALID=4`, `BUS_W=8`.
- Sub-module `bus_master_fifo`: synchronous FIFO with full/empty flags, `FIFO_DEPTH`×8, same clock and reset.
- The top contains the FSM, the counters and the dAck edge detect.

## Test plan
- **Single byte, ack on cycle 2:** write `0xA5`; target raises dAck in dValid cycle 2 → dValid high exactly 2 cycles, data=`0xA5` throughout, `done` pulses once.
- **Ack on cycle 4:** write `0x3C`, dAck in cycle 4 → dValid high 4 cycles, then low; no `err_timeout`.
- **Timeout with retry:** with `BUS_MASTER_RETRY_EN`, dAck never rises, write `0x11` → 4 bursts of 4 cycles, each separated by 1 low cycle, data=`0x11` every burst; then `err_timeout` pulses once and `busy` drops.
- **Early ack:** dAck rises in dValid cycle 1 → `err_early_ack` pulses; dValid still high exactly 2 cycles; `done` pulses.
- **Back-to-back and full:** burst-write `0x01`..`0x06` with FIFO_DEPTH=4, ack on cycle 2 → `in_ready` low while full; all six bytes appear in order, each burst 2 cycles with ≥1 low cycle between.
- **Reset mid-transfer:** assert reset in dValid cycle 2 of `0x77` with 2 bytes queued → dValid=0 and data=0 immediately; after release, no dValid without new writes.
